// File: rtl/stack_pkg.sv
// stack_pkg: opcodes, FSM states and fault codes shared by the stack pipeline
package stack_pkg;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_OVF  = 2'b01;
  localparam logic [1:0] FC_UNF  = 2'b10;
  typedef enum logic [2:0] {IDLE, WR, RD, RDW, FIN} state_t;
  function automatic logic is_wr(input logic [2:0] op);
    return op == OP_PUSH || op == OP_CALL;
  endfunction
  function automatic logic is_rd(input logic [2:0] op);
    return op == OP_POP || op == OP_RET;
  endfunction
endpackage

// File: rtl/stack_mem_unit_ram.sv
// stack_ram: single-port synchronous stack RAM with registered read data
module stack_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/stack_mem_unit.sv
// stack_mem_unit: memory half of PUSH/POP/CALL/RET against a private stack RAM
module stack_mem_unit
  import stack_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int TOP_ADDR = 1023,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  stack_op,
  input  logic [31:0] mem_sp,
  input  logic [31:0] rs_data,
  input  logic [31:0] npc,
  output logic        busy,
  output logic        done,
  output logic [31:0] lmd,
  output logic        ret_valid,
  output logic        fault,
  output logic [1:0]  fault_code
);
  state_t state, nxt;
  logic [2:0] op_q;
  logic [AW-1:0] addr_q;
  logic [31:0] wdata_q, rdata;
  logic wr_op, rd_op, oor, we;
  logic [1:0] acc_code;
  always_comb begin
    wr_op = op_valid && is_wr(stack_op);
    rd_op = op_valid && is_rd(stack_op);
    oor = mem_sp >= 32'(TOP_ADDR);
    acc_code = !oor ? FC_NONE : wr_op ? FC_OVF : FC_UNF;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // refused ops skip the RAM entirely and complete in the following cycle
  always_comb begin
    nxt = state == IDLE ? (!(wr_op || rd_op) ? IDLE : oor ? FIN : wr_op ? WR : RD) :
          state == RD   ? RDW :
          state == FIN  ? IDLE : FIN;
  end
  always_comb begin
    busy = state != IDLE;
    done = state == FIN;
    fault = done && fault_code != FC_NONE;
    ret_valid = done && op_q == OP_RET && fault_code == FC_NONE;
    we = state == WR && !rst;
  end
  // fault_code only moves when entering FIN so it stays stable until the next done
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      lmd <= '0;
      fault_code <= FC_NONE;
    end else begin
      if (state == IDLE && op_valid) begin
        op_q <= stack_op;
        addr_q <= mem_sp[AW-1:0];
        wdata_q <= stack_op == OP_CALL ? npc : rs_data;
      end
      if (state == RDW) lmd <= rdata;
      if (nxt == FIN) fault_code <= state == IDLE ? acc_code : FC_NONE;
    end
  end
  stack_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we(we),
    .addr(addr_q),
    .wdata(wdata_q),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_stack_mem_unit.sv
// tb_stack_mem_unit: directed vectors plus hand-written reset and busy sequences
module tb_stack_mem_unit;
  import stack_pkg::*;
  logic clk = 0, rst = 1, op_valid = 0;
  logic [2:0] stack_op = 0;
  logic [31:0] mem_sp = 0, rs_data = 0, npc = 0;
  logic busy, done, ret_valid, fault;
  logic [31:0] lmd;
  logic [1:0] fault_code;
  int checks = 0, failures = 0;
  logic [31:0] model [1023];

  stack_mem_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .stack_op(stack_op),
    .mem_sp(mem_sp), .rs_data(rs_data), .npc(npc), .busy(busy), .done(done),
    .lmd(lmd), .ret_valid(ret_valid), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] op; logic [31:0] sp; logic [31:0] d;
    int lat; logic f; logic [1:0] code; logic rv; logic [31:0] lmd;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic run_op(input logic [2:0] op, input logic [31:0] sp, input logic [31:0] d,
                        output int lat, output logic f, output logic [1:0] code,
                        output logic rv, output logic [31:0] l, output logic bad);
    lat = 99; f = 0; code = 0; rv = 0; l = 0;
    bad = busy;
    op_valid = 1; stack_op = op; mem_sp = sp;
    rs_data = op == OP_CALL ? ~d : d;
    npc = op == OP_CALL ? d : ~d;
    @(posedge clk);
    #1 op_valid = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!busy) bad = 1;
      if (done) begin
        lat = c; f = fault; code = fault_code; rv = ret_valid; l = lmd;
        break;
      end
    end
    @(negedge clk);
    if (done || busy) bad = 1;
  endtask

  initial begin
    int lat, errs, dones;
    logic f, rv, bad;
    logic [1:0] code;
    logic [31:0] l;
    vecs[0] = '{OP_PUSH, 32'd1022,       32'hDEADBEEF, 2, 1'b0, 2'b00, 1'b0, 32'h0};
    vecs[1] = '{OP_POP,  32'd1022,       32'h0,        3, 1'b0, 2'b00, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{OP_CALL, 32'd1021,       32'h40,       2, 1'b0, 2'b00, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{OP_RET,  32'd1021,       32'h0,        3, 1'b0, 2'b00, 1'b1, 32'h40};
    vecs[4] = '{OP_POP,  32'd1023,       32'h0,        1, 1'b1, 2'b10, 1'b0, 32'h40};
    vecs[5] = '{OP_PUSH, 32'hFFFFFFFF,   32'h99,       1, 1'b1, 2'b01, 1'b0, 32'h40};
    vecs[6] = '{OP_PUSH, 32'd0,          32'h11,       2, 1'b0, 2'b00, 1'b0, 32'h40};
    vecs[7] = '{OP_POP,  32'd0,          32'h0,        3, 1'b0, 2'b00, 1'b0, 32'h11};
    vecs[8] = '{OP_CALL, 32'd1023,       32'h77,       1, 1'b1, 2'b01, 1'b0, 32'h11};
    vecs[9] = '{OP_POP,  32'd1,          32'h0,        3, 1'b0, 2'b00, 1'b0, 32'hC0DE0001};
    repeat (2) @(negedge clk);
    chk("rst_outs", {26'b0, busy, done, ret_valid, fault, fault_code}, 32'h0);
    chk("rst_lmd", lmd, 32'h0);
    rst = 0;
    @(negedge clk);
    errs = 0;
    for (int a = 0; a < 1023; a++) begin
      model[a] = 32'hC0DE0000 | 32'(a);
      run_op(OP_PUSH, 32'(a), model[a], lat, f, code, rv, l, bad);
      if (lat != 2 || f || bad) errs++;
    end
    chk("fill_errs", 32'(errs), 32'h0);
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].sp, vecs[i].d, lat, f, code, rv, l, bad);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_fault", i), {31'b0, f}, {31'b0, vecs[i].f});
      chk($sformatf("v%0d_code", i), {30'b0, code}, {30'b0, vecs[i].code});
      chk($sformatf("v%0d_ret_valid", i), {31'b0, rv}, {31'b0, vecs[i].rv});
      chk($sformatf("v%0d_lmd", i), l, vecs[i].lmd);
      chk($sformatf("v%0d_busy_shape", i), {31'b0, bad}, 32'h0);
      if (is_wr(vecs[i].op) && !vecs[i].f) model[vecs[i].sp[9:0]] = vecs[i].d;
    end
    op_valid = 1; stack_op = OP_PUSH; mem_sp = 10; rs_data = 32'hAAAA0010;
    @(posedge clk);
    #1 mem_sp = 11; rs_data = 32'hBBBB0011;
    dones = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (c == 2) op_valid = 0;
    end
    model[10] = 32'hAAAA0010;
    chk("busy_ignore_dones", 32'(dones), 32'd1);
    run_op(OP_POP, 32'd11, 32'h0, lat, f, code, rv, l, bad);
    chk("busy_ignore_addr11", l, model[11]);
    run_op(OP_POP, 32'd10, 32'h0, lat, f, code, rv, l, bad);
    chk("busy_ignore_addr10", l, model[10]);
    for (int k = 0; k < 2; k++) begin
      op_valid = 1; stack_op = k == 0 ? 3'b000 : 3'b111; mem_sp = 3; rs_data = 32'h5555;
      @(posedge clk);
      #1 op_valid = 0;
      bad = 0;
      repeat (4) begin
        @(negedge clk);
        if (busy || done) bad = 1;
      end
      chk($sformatf("noop%0d_quiet", k), {31'b0, bad}, 32'h0);
    end
    op_valid = 1; stack_op = OP_PUSH; mem_sp = 5; rs_data = 32'h1234;
    @(posedge clk);
    #1 op_valid = 0;
    @(negedge clk);
    chk("wrrst_busy_before", {31'b0, busy}, 32'h1);
    rst = 1;
    @(negedge clk);
    chk("wrrst_outs", {26'b0, busy, done, ret_valid, fault, fault_code}, 32'h0);
    chk("wrrst_lmd", lmd, 32'h0);
    rst = 0;
    @(negedge clk);
    run_op(OP_POP, 32'd5, 32'h0, lat, f, code, rv, l, bad);
    chk("wrrst_addr5", l, model[5]);
    op_valid = 1; stack_op = OP_POP; mem_sp = 6;
    @(posedge clk);
    #1 op_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rdrst_lmd", lmd, 32'h0);
    chk("rdrst_busy", {31'b0, busy}, 32'h0);
    rst = 0;
    @(negedge clk);
    errs = 0;
    for (int a = 0; a < 1023; a++) begin
      run_op(OP_POP, 32'(a), 32'h0, lat, f, code, rv, l, bad);
      if (lat != 3 || f || bad || l !== model[a]) errs++;
    end
    chk("sweep_errs", 32'(errs), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stack_mem_unit.md
# stack_mem_unit

Executes the memory half of stack instructions: consumes the registered stack-memory address and opcode from the SP update stage and performs the word access on a private stack RAM. PUSH/CALL write a register value or return address; POP/RET read a word into the load-data register (LMD). Sits between the SP update stage and writeback/PC control, and raises `busy` to stall issue while an access is in flight.

## Interface
- `DEPTH`, 1024: stack RAM words; addresses `0..DEPTH-1`.
- `TOP_ADDR`, 1023: empty-stack SP value (the SP reset value).
- `AW`, 10: RAM index width, `clog2(DEPTH)`.
- `clk`  in  1  the single clock. All logic is posedge.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  one-cycle strobe: `stack_op`/`mem_sp` are valid.
- `stack_op`  in  3  001 PUSH, 010 POP, 011 CALL, 100 RET; other codes are no-ops.
- `mem_sp`  in  32  stack address for this access.
- `rs_data`  in  32  PUSH write data.
- `npc`  in  32  CALL write data (PC+1).
- `busy`  out  1  access in flight; the upstream stage must hold issue.
- `done`  out  1  one-cycle completion pulse.
- `lmd`  out  32  POP/RET read data, held until the next read completes.
- `ret_valid`  out  1  pulses with `done` for RET only: `lmd` is the return PC.
- `fault`  out  1  pulses with `done` when an access was refused.
- `fault_code`  out  2  00 none, 01 overflow, 10 underflow; held until the next `done`.

## Operation
- FSM states: IDLE, WR, RD, RDW, FIN.
- IDLE, `op_valid` with PUSH/CALL -> WR; POP/RET -> RD; any other code -> no action, stay IDLE.
- Opcode, address and selected write data (PUSH `rs_data`, CALL `npc`) are latched on accept.
- WR: the RAM write `mem[mem_sp[AW-1:0]]` commits at the end of this cycle -> FIN.
- RD: the RAM read address is presented -> RDW.
- RDW: RAM data is registered into `lmd` -> FIN.
- FIN: `done`=1; `ret_valid`=1 if the op was RET; -> IDLE.
- Range check on accept:
  - PUSH/CALL with `mem_sp >= TOP_ADDR` (covers wrap from SP=0): overflow. No write; `lmd` unchanged.
  - POP/RET with `mem_sp >= TOP_ADDR`: underflow (empty stack). `lmd` unchanged.
  - A refused op goes IDLE -> FIN directly, with `fault`=1 and the matching `fault_code`.
- `op_valid` while `busy` is ignored and not queued. The upstream stage must not issue while `busy`=1.
- The RAM is not cleared by reset.

## Timing
- `busy` is combinationally high in every state except IDLE. It is not high in the accept cycle.
- Upstream stalls from the cycle after accept.
- Latency from accept edge to `done`: write 2 cycles, read 3 cycles, fault 1 cycle.
- `done`, `ret_valid` and `fault` are single-cycle pulses. Back-to-back ops: the next accept is legal in the cycle after FIN.
- Reset values: state IDLE, `busy`=0, `done`=0, `ret_valid`=0, `fault`=0, `fault_code`=00, `lmd`=0.
- Reset during WR suppresses the write, because `rst` has priority over the RAM write enable.
- Reset during RD/RDW leaves `lmd`=0.
- Index uses `mem_sp[AW-1:0]` only after the range check passes. No other truncation occurs.

## Structure
- Shared package `stack_pkg`: opcode constants `OP_PUSH`/`OP_POP`/`OP_CALL`/`OP_RET` (the same encodings the SP update stage uses), the FSM state enum, and fault code constants.
- One sub-module, `stack_ram`: single-port synchronous RAM, `DEPTH` x 32, with write enable and registered read data. Top level holds the FSM, the latches and the range check.

## Test plan
- Reset, then PUSH `mem_sp`=1022, `rs_data`=0xDEADBEEF, then POP `mem_sp`=1022 -> write `done` 2 cycles after accept; read `done` 3 cycles after accept with `lmd`=0xDEADBEEF and `ret_valid`=0.
- CALL `mem_sp`=1021, `npc`=0x40, then RET `mem_sp`=1021 -> `lmd`=0x40 with `ret_valid`=1 on `done`.
- POP `mem_sp`=1023 -> `fault`=1, `fault_code`=10 one cycle after accept; `lmd` unchanged.
- PUSH `mem_sp`=0xFFFFFFFF -> `fault_code`=01. A later read of every address shows no RAM write occurred.
- Assert `op_valid` during `busy` with a different PUSH -> ignored: no extra `done`, RAM unchanged. Also: opcode 000 -> no `busy`, no `done`.
- Assert `rst` in the WR cycle of PUSH `mem_sp`=5, `rs_data`=0x1234 -> a later POP at 5 returns the prior contents, not 0x1234. All outputs read their reset values in the cycle after reset.
